// File: rtl/threshold_pkg.sv
// Shared definitions for the adaptive-thresholding datapath: controller state
// encoding and the supported upper bound on memory read latency.
package threshold_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int READ_LATENCY_MAX = 4;

endpackage

// File: rtl/threshold_raster_counter.sv
// Raster-order column/row address counter (column fastest) with clear, enable
// and a last-pixel flag; the count holds once the last pixel is reached.
module threshold_raster_counter #(
    parameter int COL_BITS = 8,
    parameter int ROW_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                enable,
    output logic [COL_BITS-1:0] col,
    output logic [ROW_BITS-1:0] row,
    output logic                last
);

    localparam logic [COL_BITS-1:0] COL_ONE = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE = ROW_BITS'(1);

    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic                last_s;

    assign last_s = (&col_q) & (&row_q);

    // Next-address selection: clear wins, otherwise step in raster order.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (enable && !last_s) begin
            if (&col_q) begin
                col_d = '0;
                row_d = row_q + ROW_ONE;
            end else begin
                col_d = col_q + COL_ONE;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign last = last_s;

endmodule

// File: rtl/threshold_adaptive.sv
// Streaming pixel-vs-threshold comparator writing one result bit per pixel.
// Optional signed threshold offset enabled by defining THRESHOLD_OFFSET_EN.
module threshold_adaptive
    import threshold_pkg::*;
#(
    parameter int WIDTH_BITS   = 8,
    parameter int HEIGHT_BITS  = 8,
    parameter int PIXEL_BITS   = 8,
    parameter int READ_LATENCY = 1,
    parameter int INVERT       = 0
) (
    input  logic                   clock,
    input  logic                   not_reset,
    input  logic                   iStart,
    output logic                   oBusy,
    output logic                   finished,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [PIXEL_BITS-1:0]  iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    input  logic [PIXEL_BITS-1:0]  iThresholdData,
`ifdef THRESHOLD_OFFSET_EN
    input  logic [PIXEL_BITS:0]    iOffset,
`endif
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    output logic                   oResultData,
    output logic                   oResultWren
);

    localparam int LAT = (READ_LATENCY < 1) ? 1 :
                         ((READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY);
    localparam logic INVERT_BIT = (INVERT != 0) ? 1'b1 : 1'b0;

    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   fin_q, fin_d;
    logic   cnt_clear_s, cnt_enable_s, cnt_last_s;
    logic [WIDTH_BITS-1:0]  cnt_col_s;
    logic [HEIGHT_BITS-1:0] cnt_row_s;

    // Stage i holds the pixel whose address was presented i+1 cycles ago.
    logic [LAT-1:0]         vld_q, vld_d;
    logic [WIDTH_BITS-1:0]  col_pipe_q [LAT];
    logic [WIDTH_BITS-1:0]  col_pipe_d [LAT];
    logic [HEIGHT_BITS-1:0] row_pipe_q [LAT];
    logic [HEIGHT_BITS-1:0] row_pipe_d [LAT];

    logic                   hit_s;
    logic                   res_wren_q, res_wren_d;
    logic                   res_data_q, res_data_d;
    logic [WIDTH_BITS-1:0]  res_col_q, res_col_d;
    logic [HEIGHT_BITS-1:0] res_row_q, res_row_d;

    threshold_raster_counter #(
        .COL_BITS (WIDTH_BITS),
        .ROW_BITS (HEIGHT_BITS)
    ) u_counter (
        .clk    (clock),
        .rst_n  (not_reset),
        .clear  (cnt_clear_s),
        .enable (cnt_enable_s),
        .col    (cnt_col_s),
        .row    (cnt_row_s),
        .last   (cnt_last_s)
    );

    // Controller next state; DRAIN ends once the last pixel has left the read pipe.
    always_comb begin
        state_d      = state_q;
        cnt_clear_s  = 1'b0;
        cnt_enable_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    cnt_clear_s = 1'b1;
                    state_d     = RUN;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                cnt_enable_s = 1'b1;
                if (cnt_last_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (vld_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN) || (state_d == DRAIN);
        fin_d  = (state_d == DONE);
    end

    // Controller state and status flags.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    // Valid/address shift register matching the memory read latency.
    always_comb begin
        vld_d         = '0;
        col_pipe_d    = col_pipe_q;
        row_pipe_d    = row_pipe_q;
        vld_d[0]      = (state_q == RUN);
        col_pipe_d[0] = cnt_col_s;
        row_pipe_d[0] = cnt_row_s;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i]      = vld_q[i-1];
            col_pipe_d[i] = col_pipe_q[i-1];
            row_pipe_d[i] = row_pipe_q[i-1];
        end
    end

    // Read-pipe registers; a reset discards any in-flight pixels.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                col_pipe_q[i] <= '0;
                row_pipe_q[i] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            col_pipe_q <= col_pipe_d;
            row_pipe_q <= row_pipe_d;
        end
    end

`ifdef THRESHOLD_OFFSET_EN
    logic signed [PIXEL_BITS+1:0] img_ext_s;
    logic signed [PIXEL_BITS+1:0] limit_s;

    // Signed compare against threshold minus offset; the extra bits keep the
    // full range exact with no saturation or wrap.
    always_comb begin
        img_ext_s = $signed({2'b00, iImageData});
        limit_s   = $signed({2'b00, iThresholdData}) - $signed({iOffset[PIXEL_BITS], iOffset});
        hit_s     = (img_ext_s > limit_s);
    end
`else
    // Plain unsigned compare at pixel width.
    always_comb begin
        hit_s = (iImageData > iThresholdData);
    end
`endif

    // Result write port; data and address only move for valid pixels.
    always_comb begin
        res_wren_d = vld_q[LAT-1];
        if (vld_q[LAT-1]) begin
            res_data_d = hit_s ^ INVERT_BIT;
            res_col_d  = col_pipe_q[LAT-1];
            res_row_d  = row_pipe_q[LAT-1];
        end else begin
            res_data_d = res_data_q;
            res_col_d  = res_col_q;
            res_row_d  = res_row_q;
        end
    end

    // Registered result outputs.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            res_wren_q <= 1'b0;
            res_data_q <= 1'b0;
            res_col_q  <= '0;
            res_row_q  <= '0;
        end else begin
            res_wren_q <= res_wren_d;
            res_data_q <= res_data_d;
            res_col_q  <= res_col_d;
            res_row_q  <= res_row_d;
        end
    end

    assign oBusy         = busy_q;
    assign finished      = fin_q;
    assign oImageCol     = cnt_col_s;
    assign oImageRow     = cnt_row_s;
    assign oThresholdCol = cnt_col_s;
    assign oThresholdRow = cnt_row_s;
    assign oResultCol    = res_col_q;
    assign oResultRow    = res_row_q;
    assign oResultData   = res_data_q;
    assign oResultWren   = res_wren_q;

endmodule

// File: tb/tb_threshold_adaptive.sv
// Directed bench for threshold_adaptive on a 4x4 image: three instances
// (latency 1, latency 3, inverted) share clock, reset and start.
module tb_threshold_adaptive;

    logic       clock     = 1'b0;
    logic       not_reset = 1'b1;
    logic       iStart    = 1'b0;
    logic       clr_mon   = 1'b0;
    logic       pix_mode  = 1'b0;
    logic [7:0] cpix      = 8'd0;
    logic [7:0] cthr      = 8'd7;
    logic [8:0] offset    = 9'd0;
    int         cyc       = 0;
    int         start_cyc = 0;
    int         n_checks  = 0;
    int         n_errors  = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] pix_fn(input logic mode, input logic [7:0] cval,
                                          input logic [1:0] r, input logic [1:0] c);
        return mode ? cval : {4'b0000, r, c};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int L   = (g == 1) ? 3 : 1;
        localparam int INV = (g == 2) ? 1 : 0;

        logic       busy, fin, wren, rdata;
        logic [1:0] icol, irow, tcol, trow, rcol, rrow;
        logic [7:0] idata, tdata;
        logic [7:0] img_pipe [L];
        logic [7:0] thr_pipe [L];
        int         wr_cnt, order_err, first_wr, last_wr, fin_rise;
        logic       fin_prev;
        logic [15:0] res;

        threshold_adaptive #(
            .WIDTH_BITS   (2),
            .HEIGHT_BITS  (2),
            .PIXEL_BITS   (8),
            .READ_LATENCY (L),
            .INVERT       (INV)
        ) u_dut (
            .clock          (clock),
            .not_reset      (not_reset),
            .iStart         (iStart),
            .oBusy          (busy),
            .finished       (fin),
            .oImageCol      (icol),
            .oImageRow      (irow),
            .iImageData     (idata),
            .oThresholdCol  (tcol),
            .oThresholdRow  (trow),
            .iThresholdData (tdata),
`ifdef THRESHOLD_OFFSET_EN
            .iOffset        (offset),
`endif
            .oResultCol     (rcol),
            .oResultRow     (rrow),
            .oResultData    (rdata),
            .oResultWren    (wren)
        );

        // Memory model with L cycles from address to data.
        always @(posedge clock) begin
            img_pipe[0] <= pix_fn(pix_mode, cpix, irow, icol);
            thr_pipe[0] <= cthr;
            for (int i = 1; i < L; i++) begin
                img_pipe[i] <= img_pipe[i-1];
                thr_pipe[i] <= thr_pipe[i-1];
            end
        end
        assign idata = img_pipe[L-1];
        assign tdata = thr_pipe[L-1];

        // Write monitor: raster order, address agreement, timing marks.
        always @(negedge clock) begin
            if (clr_mon) begin
                wr_cnt    <= 0;
                order_err <= 0;
                first_wr  <= -1;
                last_wr   <= -1;
                fin_rise  <= -1;
                fin_prev  <= 1'b0;
                res       <= 16'h0000;
            end else begin
                if (wren) begin
                    if (wr_cnt == 0) first_wr <= cyc;
                    last_wr <= cyc;
                    if ({rrow, rcol} != 4'(wr_cnt) || wr_cnt > 15) order_err <= order_err + 1;
                    res[{rrow, rcol}] <= rdata;
                    wr_cnt <= wr_cnt + 1;
                end
                if ((tcol != icol) || (trow != irow)) order_err <= order_err + 1;
                if (fin && !fin_prev) fin_rise <= cyc;
                fin_prev <= fin;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input string tag);
        @(negedge clock);
        #1 clr_mon = 1'b1;
        @(negedge clock);
        #1 clr_mon = 1'b0;
        iStart = 1'b1;
        @(negedge clock);
        start_cyc = cyc;
        check_eq({tag, " busy@start"}, 32'(gen_dut[0].busy), 32'd1);
        check_eq({tag, " fin@start"}, 32'(gen_dut[0].fin), 32'd0);
        check_eq({tag, " addr@start"}, 32'({gen_dut[0].irow, gen_dut[0].icol}), 32'd0);
        #1 iStart = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(gen_dut[0].fin && gen_dut[1].fin && gen_dut[2].fin) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, " done-in-time"}, 32'(n < 100), 32'd1);
        @(negedge clock);
        #1;
    endtask

    task automatic check_run(input string tag, input int wr, input int oerr, input int first_w,
                             input int last_w, input int fin_r, input int exp_first, input int exp_len);
        check_eq({tag, " writes"}, 32'(wr), 32'd16);
        check_eq({tag, " order"}, 32'(oerr), 32'd0);
        check_eq({tag, " first-wr-lat"}, 32'(first_w - start_cyc), 32'(exp_first));
        check_eq({tag, " fin-after-last"}, 32'(fin_r - last_w), 32'd1);
        check_eq({tag, " run-len"}, 32'(fin_r - start_cyc), 32'(exp_len));
    endtask

    initial begin
        #2 not_reset = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst wren", 32'(gen_dut[0].wren), 32'd0);
        check_eq("rst data", 32'(gen_dut[0].rdata), 32'd0);
        check_eq("rst busy", 32'(gen_dut[0].busy), 32'd0);
        check_eq("rst fin", 32'(gen_dut[0].fin), 32'd0);
        check_eq("rst addr", 32'({gen_dut[0].irow, gen_dut[0].icol, gen_dut[0].rrow, gen_dut[0].rcol}), 32'd0);
        #1 not_reset = 1'b1;
        @(negedge clock);
        check_eq("idle busy", 32'(gen_dut[1].busy), 32'd0);

        // Ramp image 4*row+col, threshold 7: pixels 8..15 exceed it.
        pix_mode = 1'b0; cthr = 8'd7;
        start_run("ramp");
        wait_done("ramp");
        check_run("ramp L1", gen_dut[0].wr_cnt, gen_dut[0].order_err, gen_dut[0].first_wr,
                  gen_dut[0].last_wr, gen_dut[0].fin_rise, 2, 18);
        check_run("ramp L3", gen_dut[1].wr_cnt, gen_dut[1].order_err, gen_dut[1].first_wr,
                  gen_dut[1].last_wr, gen_dut[1].fin_rise, 4, 20);
        check_eq("ramp L1 res", 32'(gen_dut[0].res), 32'h0000_FF00);
        check_eq("ramp L3 res", 32'(gen_dut[1].res), 32'h0000_FF00);
        check_eq("ramp inv res", 32'(gen_dut[2].res), 32'h0000_00FF);
        check_eq("ramp fin held", 32'(gen_dut[0].fin), 32'd1);

        // Equal pixel and threshold, then pixel one above.
        pix_mode = 1'b1; cpix = 8'd128; cthr = 8'd128;
        start_run("eq128");
        wait_done("eq128");
        check_eq("eq128 plain res", 32'(gen_dut[0].res), 32'h0000_0000);
        check_eq("eq128 inv res", 32'(gen_dut[2].res), 32'h0000_FFFF);
        cpix = 8'd129;
        start_run("p129");
        wait_done("p129");
        check_eq("p129 plain res", 32'(gen_dut[0].res), 32'h0000_FFFF);
        check_eq("p129 inv res", 32'(gen_dut[2].res), 32'h0000_0000);

        // Start pulse during RUN must be ignored.
        pix_mode = 1'b0; cthr = 8'd7;
        start_run("midrun");
        repeat (5) @(negedge clock);
        #1 iStart = 1'b1;
        @(negedge clock);
        check_eq("midrun busy", 32'(gen_dut[0].busy), 32'd1);
        #1 iStart = 1'b0;
        wait_done("midrun");
        check_run("midrun L1", gen_dut[0].wr_cnt, gen_dut[0].order_err, gen_dut[0].first_wr,
                  gen_dut[0].last_wr, gen_dut[0].fin_rise, 2, 18);
        check_run("midrun L3", gen_dut[1].wr_cnt, gen_dut[1].order_err, gen_dut[1].first_wr,
                  gen_dut[1].last_wr, gen_dut[1].fin_rise, 4, 20);
        check_eq("midrun res", 32'(gen_dut[0].res), 32'h0000_FF00);

        // Restart straight from DONE while finished is high.
        check_eq("done fin high", 32'(gen_dut[0].fin), 32'd1);
        start_run("restart");
        wait_done("restart");
        check_run("restart L1", gen_dut[0].wr_cnt, gen_dut[0].order_err, gen_dut[0].first_wr,
                  gen_dut[0].last_wr, gen_dut[0].fin_rise, 2, 18);
        check_eq("restart res", 32'(gen_dut[0].res), 32'h0000_FF00);

`ifdef THRESHOLD_OFFSET_EN
        // 10 > 12-3 -> 1; 255 > 253+3 -> 0; 0 > 0-1 -> 1.
        pix_mode = 1'b1; cpix = 8'd10; cthr = 8'd12; offset = 9'sd3;
        start_run("off+3");
        wait_done("off+3");
        check_eq("off+3 res", 32'(gen_dut[0].res), 32'h0000_FFFF);
        cpix = 8'd255; cthr = 8'd253; offset = -9'sd3;
        start_run("off-3");
        wait_done("off-3");
        check_eq("off-3 res", 32'(gen_dut[0].res), 32'h0000_0000);
        cpix = 8'd0; cthr = 8'd0; offset = 9'sd1;
        start_run("off+1");
        wait_done("off+1");
        check_eq("off+1 res", 32'(gen_dut[0].res), 32'h0000_FFFF);
        offset = 9'd0;
        pix_mode = 1'b0; cthr = 8'd7;
`endif

        // Asynchronous reset after the sixth write.
        begin
            int n = 0;
            start_run("reset");
            while (gen_dut[0].wr_cnt < 6 && n < 50) begin
                @(negedge clock);
                #1;
                n++;
            end
            check_eq("reset reach px6", 32'(gen_dut[0].wr_cnt), 32'd6);
        end
        not_reset = 1'b0;
        #1;
        check_eq("areset wren", 32'(gen_dut[0].wren), 32'd0);
        check_eq("areset busy", 32'(gen_dut[0].busy), 32'd0);
        check_eq("areset fin", 32'(gen_dut[0].fin), 32'd0);
        check_eq("areset data", 32'(gen_dut[0].rdata), 32'd0);
        check_eq("areset addr", 32'({gen_dut[0].irow, gen_dut[0].icol, gen_dut[0].rrow, gen_dut[0].rcol}), 32'd0);
        repeat (4) @(negedge clock);
        #1;
        check_eq("areset no more wr L1", 32'(gen_dut[0].wr_cnt), 32'd6);
        check_eq("areset no more wr L3", 32'(gen_dut[1].wr_cnt), 32'd4);
        not_reset = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("post-reset busy", 32'(gen_dut[0].busy), 32'd0);
        check_eq("post-reset fin", 32'(gen_dut[0].fin), 32'd0);
        check_eq("post-reset wr", 32'(gen_dut[0].wr_cnt), 32'd6);

        start_run("rerun");
        wait_done("rerun");
        check_run("rerun L1", gen_dut[0].wr_cnt, gen_dut[0].order_err, gen_dut[0].first_wr,
                  gen_dut[0].last_wr, gen_dut[0].fin_rise, 2, 18);
        check_eq("rerun res", 32'(gen_dut[0].res), 32'h0000_FF00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/threshold_adaptive.md
# threshold_adaptive

Parametrised, pipelined pixel thresholder for the adaptive-thresholding datapath. Streams a full image in raster order from the image memory and the per-pixel threshold memory, compares each pixel against its threshold, and writes one result bit per pixel to the result memory at one pixel per clock. It adds a start/busy/finished handshake, configurable memory read latency, an output-polarity mode and an optional signed offset, and is re-runnable without reset.

## Interface
- WIDTH_BITS, 8, log2 of image width; WIDTH = 2**WIDTH_BITS
- HEIGHT_BITS, 8, log2 of image height; HEIGHT = 2**HEIGHT_BITS
- PIXEL_BITS, 8, bits per pixel and per threshold value
- READ_LATENCY, 1, cycles from address to data on both read memories; legal values 1..4
- INVERT, 0, 0: result 1 when pixel above threshold; 1: result polarity inverted
- clock  in  1  single clock, rising edge
- not_reset  in  1  asynchronous, active-low reset
- iStart  in  1  one-cycle start pulse; accepted only in IDLE or DONE
- oBusy  out  1  high in RUN and DRAIN
- finished  out  1  high in DONE; cleared by accepted iStart or reset
- oImageCol / oImageRow  out  WIDTH_BITS / HEIGHT_BITS  image read address
- iImageData  in  PIXEL_BITS  image data, unsigned
- oThresholdCol / oThresholdRow  out  WIDTH_BITS / HEIGHT_BITS  threshold read address (always equal to image address)
- iThresholdData  in  PIXEL_BITS  threshold data, unsigned
- iOffset  in  PIXEL_BITS+1  signed two's-complement offset (present only with THRESHOLD_OFFSET_EN)
- oResultCol / oResultRow  out  WIDTH_BITS / HEIGHT_BITS  result write address
- oResultData  out  1  result bit
- oResultWren  out  1  result write enable, one cycle per pixel

## Operation
- States: IDLE (reset), RUN, DRAIN, DONE.
- IDLE/DONE + iStart: address counter to (0,0), finished to 0, go RUN.
- RUN: one address per cycle, raster order, col fastest; after (WIDTH-1, HEIGHT-1) go DRAIN. Address holds at last value.
- DRAIN: lasts until last result written, then DONE.
- DONE: finished high, holds until next accepted iStart.
- iStart during RUN/DRAIN ignored; no effect on count or outputs.
- Valid shift register of READ_LATENCY+1 stages carries col/row alongside each read.
- Compare, unsigned, widths zero-extended: hit = iImageData > iThresholdData; with offset: hit = signed(PIXEL_BITS+2) iImageData > iThresholdData − iOffset; no saturation, no wrap.
- oResultData = hit XOR INVERT.
- Every pixel written exactly once per run; no writes outside RUN/DRAIN pipeline.

## Timing
- Reset values: all addresses 0, oResultData 0, oResultWren 0, oBusy 0, finished 0, state IDLE.
- iStart sampled at edge k: address (0,0) and oBusy=1 from edge k.
- Address for pixel n presented cycle c; data sampled cycle c+READ_LATENCY; oResultWren/oResultCol/oResultRow/oResultData registered, valid cycle c+READ_LATENCY+1.
- Throughput 1 pixel/cycle; run length WIDTH*HEIGHT+READ_LATENCY+1 cycles from start edge to finished edge; finished rises the cycle after the last oResultWren.
- iStart in DONE at same cycle finished is high: accepted, finished falls next edge.
- Asynchronous reset mid-run: all outputs to reset values immediately; in-flight pixels discarded, no write.

## Configuration
- THRESHOLD_OFFSET_EN defined: iOffset port exists, offset compare used.
- Undefined: no iOffset port, plain unsigned compare, comparator PIXEL_BITS wide.

## Structure
- Shared package threshold_pkg: state encoding constants (IDLE, RUN, DRAIN, DONE), READ_LATENCY maximum (4).
- Sub-module threshold_raster_counter: col/row counter with clear, enable, last-pixel flag; reused by box-filter stage.

## Test plan
- WIDTH_BITS=HEIGHT_BITS=2, READ_LATENCY=1, pixel=4*row+col, threshold=7: 16 writes in raster order, result 1 exactly for pixels 8..15, finished 1 cycle after last write.
- READ_LATENCY=3, same image: identical results, first oResultWren 4 cycles after first address, run length 20 cycles.
- INVERT=1, pixel=threshold=128 everywhere: all 16 results 1; pixel=129: all 0.
- THRESHOLD_OFFSET_EN, pixel=10, threshold=12, iOffset=+3: result 1; iOffset=−3 with pixel=255, threshold=253: result 0.
- iStart pulsed mid-RUN, then again in DONE: first ignored (16 writes), second starts a clean 16-write run.
- not_reset low at pixel 6: outputs to reset values at once, no further writes, state IDLE, finished 0.
